// File: rtl/fixed_point_requantizer.sv
`default_nettype none
// ============================================================================
// Module      : fixed_point_requantizer
// Description : Streaming fixed-point format converter with rounding and
//               saturation. Two-stage valid/ready pipeline (align+round,
//               then saturate) with per-sample, sticky and counted
//               saturation status.
// Revision    : 1.0 - initial release
// ============================================================================
module fixed_point_requantizer #(
    parameter int IN_BITS   = 16,
    parameter int IN_FRAC   = 15,
    parameter int OUT_BITS  = 8,
    parameter int OUT_FRAC  = 7,
    parameter int IS_SIGNED = 1,
    parameter int ROUND     = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [IN_BITS-1:0]  in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OUT_BITS-1:0] out_data,
    output logic                out_sat,
    input  logic                sat_clear,
    output logic                sat_sticky,
    output logic [15:0]         sat_count
);

    localparam int C_IN_WHOLE  = IN_BITS - IN_FRAC;
    localparam int C_OUT_WHOLE = OUT_BITS - OUT_FRAC;
    localparam int C_SHIFT     = IN_FRAC - OUT_FRAC;
    // Two guard bits: one for the rounding carry, one so unsigned values stay positive.
    localparam int C_MID_W     = ((C_IN_WHOLE > C_OUT_WHOLE) ? C_IN_WHOLE : C_OUT_WHOLE)
                                 + OUT_FRAC + 2;
    localparam int C_EXT_W     = C_MID_W + ((C_SHIFT > 0) ? C_SHIFT : 0);

    localparam logic signed [C_MID_W-1:0] C_MAX = (IS_SIGNED != 0) ?
        C_MID_W'((64'sd1 <<< (OUT_BITS - 1)) - 64'sd1) :
        C_MID_W'((64'sd1 <<< OUT_BITS) - 64'sd1);
    localparam logic signed [C_MID_W-1:0] C_MIN = (IS_SIGNED != 0) ?
        C_MID_W'(-(64'sd1 <<< (OUT_BITS - 1))) : '0;

    // Pipeline and status state
    logic                       s1_valid_q, s1_valid_d;
    logic signed [C_MID_W-1:0]  s1_data_q,  s1_data_d;
    logic                       out_valid_q, out_valid_d;
    logic [OUT_BITS-1:0]        out_data_q,  out_data_d;
    logic                       out_sat_q,   out_sat_d;
    logic                       sat_sticky_q, sat_sticky_d;
    logic [15:0]                sat_count_q,  sat_count_d;

    logic                       adv;
    logic                       xfer_sat;
    logic                       ext_bit;
    logic signed [C_EXT_W-1:0]  ext_in;
    logic signed [C_MID_W-1:0]  aligned;
    logic                       sat_hi;
    logic                       sat_lo;
    logic signed [C_MID_W-1:0]  sat_val;
    logic                       unused_sat_msbs;

    // Sign- or zero-extend so that every later operation is plain signed math.
    assign ext_bit = (IS_SIGNED != 0) ? in_data[IN_BITS-1] : 1'b0;
    assign ext_in  = {{(C_EXT_W - IN_BITS){ext_bit}}, in_data};

    generate
        if (C_SHIFT > 0) begin : g_shr
            logic signed [C_EXT_W-1:0] half_lsb;
            logic signed [C_EXT_W-1:0] rounded;
            logic                      unused_round_bits;
            assign half_lsb = (ROUND != 0) ? (C_EXT_W'(1) << (C_SHIFT - 1)) : '0;
            assign rounded  = ext_in + half_lsb;
            // Taking the top bits is the arithmetic right shift by C_SHIFT.
            assign aligned  = rounded[C_EXT_W-1:C_SHIFT];
            assign unused_round_bits = ^rounded[C_SHIFT-1:0];
        end else begin : g_shl
            assign aligned = ext_in <<< (-C_SHIFT);
        end
    endgenerate

    // Clamp the aligned S1 value into the output range.
    always_comb begin
        sat_hi  = (s1_data_q > C_MAX);
        sat_lo  = (s1_data_q < C_MIN);
        sat_val = s1_data_q;
        if (sat_hi) begin
            sat_val = C_MAX;
        end else if (sat_lo) begin
            sat_val = C_MIN;
        end
    end

    assign unused_sat_msbs = ^sat_val[C_MID_W-1:OUT_BITS];

    assign adv      = !out_valid_q || out_ready;
    assign xfer_sat = out_valid_q && out_ready && out_sat_q;

    // Next-state: global stall pipeline plus saturation status bookkeeping.
    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_data_d    = s1_data_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_sat_d    = out_sat_q;
        sat_sticky_d = sat_sticky_q;
        sat_count_d  = sat_count_q;

        if (adv) begin
            s1_valid_d  = in_valid;
            if (in_valid) begin
                s1_data_d = aligned;
            end
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_data_d = sat_val[OUT_BITS-1:0];
                out_sat_d  = sat_hi || sat_lo;
            end else begin
                out_sat_d  = 1'b0;
            end
        end

        if (sat_clear) begin
            sat_sticky_d = xfer_sat;
            sat_count_d  = {15'd0, xfer_sat};
        end else if (xfer_sat) begin
            sat_sticky_d = 1'b1;
            if (sat_count_q != 16'hFFFF) begin
                sat_count_d = sat_count_q + 16'd1;
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q   <= 1'b0;
            s1_data_q    <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_sat_q    <= 1'b0;
            sat_sticky_q <= 1'b0;
            sat_count_q  <= 16'd0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_data_q    <= s1_data_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_sat_q    <= out_sat_d;
            sat_sticky_q <= sat_sticky_d;
            sat_count_q  <= sat_count_d;
        end
    end

    assign in_ready   = adv;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_sat    = out_sat_q;
    assign sat_sticky = sat_sticky_q;
    assign sat_count  = sat_count_q;

endmodule
`default_nettype wire

// File: tb/tb_fixed_point_requantizer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_fixed_point_requantizer
// Description : Scoreboard bench for fixed_point_requantizer. Stimulus pushes
//               expected samples; a monitor pops them on every output transfer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fixed_point_requantizer;

    localparam int P_IN_BITS  = 16;
    localparam int P_IN_FRAC  = 15;
    localparam int P_OUT_BITS = 8;
    localparam int P_OUT_FRAC = 7;
    localparam int P_SIGNED   = 1;
    localparam int P_ROUND    = 1;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_sat;
    logic        sat_clear;
    logic        sat_sticky;
    logic [15:0] sat_count;

    // Auxiliary configurations, driven together with fixed vectors
    logic        aux_valid;
    logic        aux_ready = 1'b1;
    logic        aux_clear = 1'b0;
    logic [15:0] t_in;
    logic [7:0]  w_in, u_in;
    logic        t_ir, t_ov, t_os, t_st;
    logic        w_ir, w_ov, w_os, w_st;
    logic        u_ir, u_ov, u_os, u_st;
    logic [7:0]  t_od;
    logic [15:0] w_od;
    logic [3:0]  u_od;
    logic [15:0] t_cnt, w_cnt, u_cnt;

    int total = 0;
    int bad   = 0;
    int ready_mode = 0;     // 0: always ready, 1: random, 2: scripted stall
    int stall_seen = 0;

    typedef struct {
        logic [7:0] d;
        logic       s;
        time        t;
        bit         lat;
    } exp_t;
    exp_t sbq[$];

    always #5 clk = ~clk;

    fixed_point_requantizer #(
        .IN_BITS(P_IN_BITS), .IN_FRAC(P_IN_FRAC), .OUT_BITS(P_OUT_BITS),
        .OUT_FRAC(P_OUT_FRAC), .IS_SIGNED(P_SIGNED), .ROUND(P_ROUND)
    ) u_dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_sat(out_sat), .sat_clear(sat_clear),
        .sat_sticky(sat_sticky), .sat_count(sat_count)
    );

    fixed_point_requantizer #(
        .IN_BITS(16), .IN_FRAC(15), .OUT_BITS(8), .OUT_FRAC(7), .IS_SIGNED(1), .ROUND(0)
    ) u_trunc (
        .clk(clk), .reset_n(reset_n), .in_valid(aux_valid), .in_ready(t_ir),
        .in_data(t_in), .out_valid(t_ov), .out_ready(aux_ready), .out_data(t_od),
        .out_sat(t_os), .sat_clear(aux_clear), .sat_sticky(t_st), .sat_count(t_cnt)
    );

    fixed_point_requantizer #(
        .IN_BITS(8), .IN_FRAC(4), .OUT_BITS(16), .OUT_FRAC(8), .IS_SIGNED(1), .ROUND(1)
    ) u_widen (
        .clk(clk), .reset_n(reset_n), .in_valid(aux_valid), .in_ready(w_ir),
        .in_data(w_in), .out_valid(w_ov), .out_ready(aux_ready), .out_data(w_od),
        .out_sat(w_os), .sat_clear(aux_clear), .sat_sticky(w_st), .sat_count(w_cnt)
    );

    fixed_point_requantizer #(
        .IN_BITS(8), .IN_FRAC(0), .OUT_BITS(4), .OUT_FRAC(0), .IS_SIGNED(0), .ROUND(1)
    ) u_uns (
        .clk(clk), .reset_n(reset_n), .in_valid(aux_valid), .in_ready(u_ir),
        .in_data(u_in), .out_valid(u_ov), .out_ready(aux_ready), .out_data(u_od),
        .out_sat(u_os), .sat_clear(aux_clear), .sat_sticky(u_st), .sat_count(u_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint floor_div(input longint a, input longint b);
        longint q;
        q = a / b;
        if ((a % b != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    // Reference: real value x * 2^-IN_FRAC rescaled to 2^-OUT_FRAC, rounded, clamped.
    function automatic void model(input logic [15:0] x, output logic [7:0] d, output logic s);
        longint v, num, den, r, mx, mn;
        v   = (P_SIGNED != 0) ? longint'($signed(x)) : longint'(x);
        num = v * (longint'(1) << P_OUT_FRAC);
        den = longint'(1) << P_IN_FRAC;
        r   = (P_ROUND != 0) ? floor_div(2 * num + den, 2 * den) : floor_div(num, den);
        mx  = (P_SIGNED != 0) ? (longint'(1) << (P_OUT_BITS - 1)) - 1 : (longint'(1) << P_OUT_BITS) - 1;
        mn  = (P_SIGNED != 0) ? -(longint'(1) << (P_OUT_BITS - 1)) : 0;
        s   = 1'b0;
        if (r > mx) begin r = mx; s = 1'b1; end
        else if (r < mn) begin r = mn; s = 1'b1; end
        d = 8'(r);
    endfunction

    // Output-ready pattern generator
    initial begin : ready_gen
        int bp;
        bp = 0;
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0: begin out_ready = 1'b1; bp = 0; end
                1: out_ready = ($urandom_range(0, 2) != 0);
                default: begin bp++; out_ready = !(bp >= 3 && bp <= 7); end
            endcase
        end
    end

    // Monitor: pops the scoreboard on each transfer and tracks the status model
    initial begin : monitor
        logic       have_prev;
        logic [7:0] prev_data;
        logic       xs;
        int         exp_cnt;
        bit         exp_sticky;
        exp_t       e;
        have_prev  = 1'b0;
        prev_data  = '0;
        exp_cnt    = 0;
        exp_sticky = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                sbq.delete();
                exp_cnt    = 0;
                exp_sticky = 1'b0;
                have_prev  = 1'b0;
            end else begin
                chk("in_ready", {31'd0, in_ready}, {31'd0, (!out_valid || out_ready)});
                chk("sat_count", {16'd0, sat_count}, exp_cnt);
                chk("sat_sticky", {31'd0, sat_sticky}, {31'd0, exp_sticky});
                if (have_prev) begin
                    chk("hold_valid", {31'd0, out_valid}, 32'd1);
                    chk("hold_data", {24'd0, out_data}, {24'd0, prev_data});
                end
                have_prev = out_valid && !out_ready;
                prev_data = out_data;
                if (!in_ready) stall_seen++;
                xs = 1'b0;
                if (out_valid && out_ready) begin
                    if (sbq.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_output: got 0x%0h want none at %0t", out_data, $time);
                    end else begin
                        e = sbq.pop_front();
                        chk("out_data", {24'd0, out_data}, {24'd0, e.d});
                        chk("out_sat", {31'd0, out_sat}, {31'd0, e.s});
                        if (e.lat) chk("latency_ns", 32'($time - e.t), 32'd20);
                        xs = e.s;
                    end
                end
                if (sat_clear) begin
                    exp_sticky = xs;
                    exp_cnt    = xs ? 1 : 0;
                end else if (xs) begin
                    exp_sticky = 1'b1;
                    if (exp_cnt < 65535) exp_cnt++;
                end
            end
        end
    end

    // Present one sample (called at posedge+1); push expectation on acceptance.
    task automatic drive(input logic [15:0] x, input logic [7:0] ed, input logic es, input bit lat);
        exp_t e;
        int   w;
        bit   ok;
        in_valid = 1'b1;
        in_data  = x;
        ok = 1'b0;
        for (w = 0; w < 50; w++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got in_ready=0 want 1 for 0x%0h", x);
            in_valid = 1'b0;
        end else begin
            e.d = ed; e.s = es; e.t = $time; e.lat = lat;
            sbq.push_back(e);
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic drive_model(input logic [15:0] x, input bit lat);
        logic [7:0] d;
        logic       s;
        model(x, d, s);
        drive(x, d, s, lat);
    endtask

    task automatic drain();
        int w;
        for (w = 0; w < 200 && sbq.size() != 0; w++) begin
            @(posedge clk); #1;
        end
        chk("drain_left", sbq.size(), 32'd0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic aux_vec(input logic [15:0] ti, input logic [7:0] wi, input logic [7:0] ui,
                           input logic [7:0] td, input logic ts, input logic [15:0] wd,
                           input logic [3:0] ud, input logic us);
        int  w;
        bit  seen;
        aux_valid = 1'b1;
        t_in = ti; w_in = wi; u_in = ui;
        @(posedge clk); #1;
        aux_valid = 1'b0;
        seen = 1'b0;
        for (w = 0; w < 10; w++) begin
            @(negedge clk);
            if (t_ov) begin seen = 1'b1; break; end
        end
        chk("aux_seen", {31'd0, seen}, 32'd1);
        chk("trunc_data", {24'd0, t_od}, {24'd0, td});
        chk("trunc_sat", {31'd0, t_os}, {31'd0, ts});
        chk("widen_valid", {31'd0, w_ov}, 32'd1);
        chk("widen_data", {16'd0, w_od}, {16'd0, wd});
        chk("widen_sat", {31'd0, w_os}, 32'd0);
        chk("uns_data", {28'd0, u_od}, {28'd0, ud});
        chk("uns_sat", {31'd0, u_os}, {31'd0, us});
        @(posedge clk); #1;
    endtask

    initial begin : stim
        int s0;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        sat_clear = 1'b0;
        aux_valid = 1'b0;
        t_in = '0; w_in = '0; u_in = '0;
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", {24'd0, out_data}, 32'd0);
        chk("rst_out_sat", {31'd0, out_sat}, 32'd0);
        chk("rst_sticky", {31'd0, sat_sticky}, 32'd0);
        chk("rst_count", {16'd0, sat_count}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        idle(2);

        // Directed Q1.15 -> Q1.7 rounding vectors
        drive(16'h4080, 8'h41, 1'b0, 1'b1);
        drive(16'h3F7F, 8'h3F, 1'b0, 1'b1);
        drive(16'hFF80, 8'h00, 1'b0, 1'b1);
        drive(16'h8000, 8'h80, 1'b0, 1'b1);
        drive(16'h7FFF, 8'h7F, 1'b1, 1'b1);
        drain();
        idle(1);
        chk("dir_sticky", {31'd0, sat_sticky}, 32'd1);
        chk("dir_count", {16'd0, sat_count}, 32'd1);

        // Other configurations
        aux_vec(16'h7FFF, 8'hF8, 8'h20, 8'h7F, 1'b0, 16'hFF80, 4'hF, 1'b1);
        aux_vec(16'h8000, 8'h7F, 8'h0F, 8'h80, 1'b0, 16'h07F0, 4'hF, 1'b0);

        sat_clear = 1'b1;
        idle(1);
        sat_clear = 1'b0;

        // Randomized stream with random back-pressure and occasional clears
        ready_mode = 1;
        for (int i = 0; i < 1500; i++) begin
            logic [15:0] x;
            case ($urandom_range(0, 7))
                0: x = 16'h7FFF;
                1: x = 16'h7F80;
                2: x = 16'h7F7F;
                3: x = 16'h8000;
                default: x = 16'($urandom);
            endcase
            sat_clear = ($urandom_range(0, 30) == 0);
            drive_model(x, 1'b0);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        sat_clear = 1'b0;
        drain();
        ready_mode = 0;
        idle(2);

        // Back-pressure: out_ready low for cycles 3..7 of the stream
        s0 = stall_seen;
        ready_mode = 2;
        for (int i = 1; i <= 5; i++) begin
            drive(16'(i << 8), 8'(i), 1'b0, 1'b0);
        end
        drain();
        chk("bp_in_ready_dropped", {31'd0, (stall_seen > s0)}, 32'd1);
        ready_mode = 0;
        idle(2);

        // Counter saturation at 0xFFFF, then clear coinciding with a saturated transfer
        sat_clear = 1'b1;
        idle(1);
        sat_clear = 1'b0;
        for (int i = 0; i < 70000; i++) begin
            drive(16'h7FFF, 8'h7F, 1'b1, 1'b1);
        end
        chk("count_max", {16'd0, sat_count}, 32'h0000FFFF);
        sat_clear = 1'b1;
        @(posedge clk); #1;
        sat_clear = 1'b0;
        chk("clear_xfer_count", {16'd0, sat_count}, 32'd1);
        chk("clear_xfer_sticky", {31'd0, sat_sticky}, 32'd1);
        drain();
        idle(1);

        // Reset with two samples in flight
        drive(16'h7FFF, 8'h7F, 1'b1, 1'b1);
        drive(16'h7FFF, 8'h7F, 1'b1, 1'b1);
        #1;
        reset_n = 1'b0;
        #1;
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_count", {16'd0, sat_count}, 32'd0);
        chk("midrst_sticky", {31'd0, sat_sticky}, 32'd0);
        @(negedge clk);
        @(posedge clk); #1;
        reset_n = 1'b1;
        idle(3);
        drive(16'h4080, 8'h41, 1'b0, 1'b1);
        drain();
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
